// File: rtl/uart_verici_kuyrugu.sv
// uart_verici_kuyrugu: transmit byte FIFO feeding a UART transmitter.
// The head byte stays on veri_o for the whole frame and is popped only after the frame completes.
module uart_verici_kuyrugu #(
    parameter  int DERINLIK = 16,
    localparam int SAYAC_W  = $clog2(DERINLIK + 1)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               yaz_gecerli_i,
    input  logic [7:0]         yaz_veri_i,
    output logic               yaz_hazir_o,
    input  logic               temizle_i,
    input  logic               verici_hazir_i,
    output logic [7:0]         veri_o,
    output logic               veri_gecerli_o,
    output logic               basla_o,
    output logic               mesgul_o,
    output logic               bos_o,
    output logic               dolu_o,
    output logic [SAYAC_W-1:0] doluluk_o
);
    localparam int PTR_W = $clog2(DERINLIK);
    typedef enum logic [1:0] {BOSTA, BASLAT, GONDERIM} durum_e;
    durum_e durum_q, durum_d;
    logic [7:0] mem_q [DERINLIK];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SAYAC_W-1:0] sayac_q, sayac_d;
    logic yaz, cek;

    assign bos_o          = sayac_q == '0;
    assign dolu_o         = sayac_q == SAYAC_W'(DERINLIK);
    assign yaz_hazir_o    = !dolu_o;
    assign veri_gecerli_o = !bos_o;
    assign doluluk_o      = sayac_q;
    assign veri_o         = mem_q[rd_ptr_q];
    // a flush discards the write and any pop of the same cycle
    assign yaz = yaz_gecerli_i && !dolu_o && !temizle_i;
    assign cek = durum_q == GONDERIM && verici_hazir_i && !temizle_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q  <= BOSTA;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sayac_q  <= '0;
        end else begin
            durum_q  <= durum_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sayac_q  <= sayac_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (yaz) mem_q[wr_ptr_q] <= yaz_veri_i;
    end

    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOSTA:    durum_d = (!bos_o && verici_hazir_i) ? BASLAT : BOSTA;
            BASLAT:   durum_d = verici_hazir_i ? BASLAT : GONDERIM;
            GONDERIM: durum_d = verici_hazir_i ? BOSTA : GONDERIM;
            default:  durum_d = BOSTA;
        endcase
        if (temizle_i) durum_d = BOSTA;
    end

    always_comb begin
        wr_ptr_d = temizle_i ? '0 : wr_ptr_q + PTR_W'(yaz);
        rd_ptr_d = temizle_i ? '0 : rd_ptr_q + PTR_W'(cek);
        sayac_d  = temizle_i ? '0 : sayac_q + SAYAC_W'(yaz) - SAYAC_W'(cek);
    end

    always_comb begin
        basla_o  = durum_q == BASLAT;
        mesgul_o = durum_q != BOSTA;
    end
endmodule
